// File: rtl/rice_residual_encoder_pkg.sv
// -----------------------------------------------------------------------------
// rice_residual_encoder_pkg
//   Shared definitions for the Rice residual encoder: Rice parameter width and
//   ceiling, bit-index width of a packed RAM word, encoder FSM state codes and
//   the Rice parameter clamp helper.
// -----------------------------------------------------------------------------
package rice_residual_encoder_pkg;

    localparam int RICE_PARAM_W = 4;
    localparam logic [RICE_PARAM_W-1:0] RICE_PARAM_MAX = 4'd14;

    // Bit index inside a 16-bit RAM word (15 = MSB = first bit written)
    localparam int BIT_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_UNARY = 3'd2,
        ST_STOP  = 3'd3,
        ST_LSB   = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } enc_state_t;

    // The 4-bit header field can carry 15, but 15 is reserved as an escape
    // code by the decoder, so the usable parameter tops out at 14.
    function automatic logic [RICE_PARAM_W-1:0] clamp_rice_param(
        input logic [RICE_PARAM_W-1:0] p
    );
        return (p > RICE_PARAM_MAX) ? RICE_PARAM_MAX : p;
    endfunction

endpackage

// File: rtl/rice_residual_encoder_bit_packer.sv
// -----------------------------------------------------------------------------
// rice_residual_encoder_bit_packer
//   Serial-in bit packer. Bits are placed MSB-first into a word buffer (bit 15
//   first, index counting down). When bit 0 is filled the word is queued for a
//   one-cycle write strobe in the next enabled cycle and packing moves on to
//   the next address without stalling.
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                clock enable; low freezes all state and holds strobes
//   i_start_addr/bit/word  preload loaded during reset (bits above start bit kept)
//   i_bit_vld, i_bit    one serial bit to pack this cycle
//   i_flush             write out a partially filled word (if any)
//   o_wdata/o_waddr/o_we   RAM write port
//   o_end_addr/o_end_bit   next free bit position
// -----------------------------------------------------------------------------
module rice_residual_encoder_bit_packer
    import rice_residual_encoder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_start_addr,
    input  logic [BIT_IDX_W-1:0] i_start_bit,
    input  logic [DATA_W-1:0]    i_start_word,
    input  logic                 i_bit_vld,
    input  logic                 i_bit,
    input  logic                 i_flush,
    output logic [DATA_W-1:0]    o_wdata,
    output logic [ADDR_W-1:0]    o_waddr,
    output logic                 o_we,
    output logic [ADDR_W-1:0]    o_end_addr,
    output logic [BIT_IDX_W-1:0] o_end_bit
);

    logic [DATA_W-1:0]    r_buf;
    logic [DATA_W-1:0]    r_wdata;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_waddr;
    logic [BIT_IDX_W-1:0] r_bit;
    logic                 r_pend;

    logic [DATA_W-1:0]    w_keep_mask;
    logic [DATA_W-1:0]    w_buf_ins;

    // Keep only the bits strictly above the start bit; everything at or below
    // it is zero so later bits can simply be OR-ed in and a flush is padded.
    assign w_keep_mask = ({DATA_W{1'b1}} << i_start_bit) << 1;
    assign w_buf_ins   = r_buf | ({{(DATA_W-1){1'b0}}, i_bit} << r_bit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= i_start_addr;
            r_bit   <= i_start_bit;
            r_buf   <= i_start_word & w_keep_mask;
            r_pend  <= 1'b0;
            r_wdata <= '0;
            r_waddr <= '0;
        end else if (i_en) begin
            // A queued strobe is issued during this enabled cycle.
            r_pend <= 1'b0;
            if (i_bit_vld) begin
                if (r_bit == '0) begin
                    r_wdata <= w_buf_ins;
                    r_waddr <= r_addr;
                    r_pend  <= 1'b1;
                    r_addr  <= r_addr + 1'b1;
                    r_bit   <= BIT_IDX_W'(DATA_W - 1);
                    r_buf   <= '0;
                end else begin
                    r_buf <= w_buf_ins;
                    r_bit <= r_bit - 1'b1;
                end
            end else if (i_flush && (r_bit != BIT_IDX_W'(DATA_W - 1))) begin
                r_wdata <= r_buf;
                r_waddr <= r_addr;
                r_pend  <= 1'b1;
            end
        end
    end

    // Strobe only in enabled, non-reset cycles so a stalled or abandoned
    // word never reaches the RAM early.
    assign o_we       = r_pend & i_en & ~i_rst;
    assign o_wdata    = r_wdata;
    assign o_waddr    = r_waddr;
    assign o_end_addr = r_addr;
    assign o_end_bit  = r_bit;

endmodule

// File: rtl/rice_residual_encoder.sv
// -----------------------------------------------------------------------------
// rice_residual_encoder
//   Rice encoder for signed residuals. Each partition starts with a 4-bit
//   Rice parameter header; each residual is zig-zag mapped to u, then coded as
//   q=u>>k zeros, a stop 1, and the k low bits of u. One bit is packed per
//   enabled cycle into 16-bit RAM words, MSB first, compatible with the
//   residual decoder.
// Ports
//   iClock, iReset, iEnable      clock, sync active-high reset, clock enable
//   iBlockSize/iPredictorOrder/iPartitionOrder  block geometry (sampled in reset)
//   iStartAddr/iStartBit/iStartWord  output preload (sampled in reset)
//   iRiceParam                   k for the next partition, sampled at its header
//   iResidual/iValid/oReady      residual input handshake
//   oWriteData/oWriteAddr/oWriteEnable  RAM write port
//   oDone/oEndAddr/oEndBit       block-complete pulse and next free bit position
// -----------------------------------------------------------------------------
module rice_residual_encoder
    import rice_residual_encoder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic                        iEnable,
    input  logic [15:0]                 iBlockSize,
    input  logic [3:0]                  iPredictorOrder,
    input  logic [3:0]                  iPartitionOrder,
    input  logic [ADDR_W-1:0]           iStartAddr,
    input  logic [BIT_IDX_W-1:0]        iStartBit,
    input  logic [DATA_W-1:0]           iStartWord,
    input  logic [RICE_PARAM_W-1:0]     iRiceParam,
    input  logic signed [DATA_W-1:0]    iResidual,
    input  logic                        iValid,
    output logic                        oReady,
    output logic [DATA_W-1:0]           oWriteData,
    output logic [ADDR_W-1:0]           oWriteAddr,
    output logic                        oWriteEnable,
    output logic                        oDone,
    output logic [ADDR_W-1:0]           oEndAddr,
    output logic [BIT_IDX_W-1:0]        oEndBit
);

    function automatic logic [DATA_W-1:0] zigzag(input logic signed [DATA_W-1:0] r);
        return {r[DATA_W-2:0], 1'b0} ^ {DATA_W{r[DATA_W-1]}};
    endfunction

    enc_state_t                r_state;
    logic [RICE_PARAM_W-1:0]   r_k;
    logic [1:0]                r_hdr_cnt;
    logic [DATA_W-1:0]         r_u;
    logic [DATA_W-1:0]         r_q_cnt;
    logic [RICE_PARAM_W-1:0]   r_lsb_idx;
    logic [15:0]               r_samp_left;
    logic [15:0]               r_part_len;
    logic [16:0]               r_parts_left;
    logic                      r_ready;
    logic                      r_done;
    logic [ADDR_W-1:0]         r_end_addr;
    logic [BIT_IDX_W-1:0]      r_end_bit;

    logic [RICE_PARAM_W-1:0]   w_k_in;
    logic [DATA_W-1:0]         w_u;
    logic [DATA_W-1:0]         w_q;
    logic [15:0]               w_part_len;
    logic [15:0]               w_part0_len;
    logic                      w_bit_vld;
    logic                      w_bit;
    logic                      w_flush;
    logic                      w_seg_end;
    enc_state_t                w_after_state;
    logic [ADDR_W-1:0]         w_pk_end_addr;
    logic [BIT_IDX_W-1:0]      w_pk_end_bit;

    assign w_k_in      = clamp_rice_param(iRiceParam);
    assign w_u         = zigzag(iResidual);
    assign w_q         = w_u >> r_k;
    assign w_part_len  = iBlockSize >> iPartitionOrder;
    // Warm-up samples come out of partition 0; a too-short partition is empty.
    assign w_part0_len = (w_part_len > 16'(iPredictorOrder)) ?
                         (w_part_len - 16'(iPredictorOrder)) : 16'd0;

    // Serial bit source for the packer
    always_comb begin
        w_bit_vld = 1'b0;
        w_bit     = 1'b0;
        w_flush   = 1'b0;
        w_seg_end = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_bit_vld = 1'b1;
                // First header cycle codes straight from the input it latches.
                w_bit     = (r_hdr_cnt == 2'd0) ? w_k_in[3] : r_k[2'd3 - r_hdr_cnt];
                w_seg_end = (r_hdr_cnt == 2'd3);
            end
            ST_UNARY: begin
                w_bit_vld = 1'b1;
                w_bit     = 1'b0;
            end
            ST_STOP: begin
                w_bit_vld = 1'b1;
                w_bit     = 1'b1;
                w_seg_end = (r_k == '0);
            end
            ST_LSB: begin
                w_bit_vld = 1'b1;
                w_bit     = r_u[r_lsb_idx];
                w_seg_end = (r_lsb_idx == '0);
            end
            ST_FLUSH: w_flush = 1'b1;
            default: ;
        endcase
    end

    // Where to go once a header or a sample's last bit is out: more samples
    // in this partition, another partition header, or the final flush.
    always_comb begin
        if (r_samp_left != 16'd0)
            w_after_state = ST_WAIT;
        else if (r_parts_left > 17'd1)
            w_after_state = ST_HDR;
        else
            w_after_state = ST_FLUSH;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state      <= ST_HDR;
            r_hdr_cnt    <= 2'd0;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_end_addr   <= '0;
            r_end_bit    <= BIT_IDX_W'(DATA_W - 1);
            r_part_len   <= w_part_len;
            r_samp_left  <= w_part0_len;
            r_parts_left <= 17'd1 << iPartitionOrder;
        end else begin
            r_done <= 1'b0;
            if (iEnable) begin
                case (r_state)
                    ST_HDR: begin
                        if (r_hdr_cnt == 2'd0)
                            r_k <= w_k_in;
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                    end
                    ST_WAIT: begin
                        if (iValid && r_ready) begin
                            r_ready     <= 1'b0;
                            r_u         <= w_u;
                            r_q_cnt     <= w_q;
                            r_samp_left <= r_samp_left - 16'd1;
                            r_state     <= (w_q == '0) ? ST_STOP : ST_UNARY;
                        end
                    end
                    ST_UNARY: begin
                        r_q_cnt <= r_q_cnt - 1'b1;
                        if (r_q_cnt == DATA_W'(1))
                            r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_lsb_idx <= r_k - 1'b1;
                        r_state   <= ST_LSB;
                    end
                    ST_LSB: begin
                        r_lsb_idx <= r_lsb_idx - 1'b1;
                    end
                    ST_FLUSH: begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_end_addr <= w_pk_end_addr;
                        r_end_bit  <= w_pk_end_bit;
                    end
                    default: ;
                endcase

                // Overrides the per-state next state at segment boundaries.
                if (w_seg_end) begin
                    r_state <= w_after_state;
                    r_ready <= (w_after_state == ST_WAIT);
                    if ((r_samp_left == 16'd0) && (r_parts_left > 17'd1)) begin
                        r_parts_left <= r_parts_left - 17'd1;
                        r_samp_left  <= r_part_len;
                    end
                end
            end
        end
    end

    rice_residual_encoder_bit_packer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .i_clk        (iClock),
        .i_rst        (iReset),
        .i_en         (iEnable),
        .i_start_addr (iStartAddr),
        .i_start_bit  (iStartBit),
        .i_start_word (iStartWord),
        .i_bit_vld    (w_bit_vld),
        .i_bit        (w_bit),
        .i_flush      (w_flush),
        .o_wdata      (oWriteData),
        .o_waddr      (oWriteAddr),
        .o_we         (oWriteEnable),
        .o_end_addr   (w_pk_end_addr),
        .o_end_bit    (w_pk_end_bit)
    );

    assign oReady   = r_ready;
    assign oDone    = r_done;
    assign oEndAddr = r_end_addr;
    assign oEndBit  = r_end_bit;

endmodule

// File: tb/tb_rice_residual_encoder.sv
// -----------------------------------------------------------------------------
// tb_rice_residual_encoder
//   Directed bench for rice_residual_encoder with hand-computed bitstreams.
// -----------------------------------------------------------------------------
module tb_rice_residual_encoder;

    logic               clk = 1'b0;
    logic               iReset;
    logic               iEnable;
    logic [15:0]        iBlockSize;
    logic [3:0]         iPredictorOrder;
    logic [3:0]         iPartitionOrder;
    logic [15:0]        iStartAddr;
    logic [3:0]         iStartBit;
    logic [15:0]        iStartWord;
    logic [3:0]         iRiceParam;
    logic signed [15:0] iResidual;
    logic               iValid;
    logic               oReady;
    logic [15:0]        oWriteData;
    logic [15:0]        oWriteAddr;
    logic               oWriteEnable;
    logic               oDone;
    logic [15:0]        oEndAddr;
    logic [3:0]         oEndBit;

    always #5 clk = ~clk;

    rice_residual_encoder #(.DATA_W(16), .ADDR_W(16)) dut (
        .iClock          (clk),
        .iReset          (iReset),
        .iEnable         (iEnable),
        .iBlockSize      (iBlockSize),
        .iPredictorOrder (iPredictorOrder),
        .iPartitionOrder (iPartitionOrder),
        .iStartAddr      (iStartAddr),
        .iStartBit       (iStartBit),
        .iStartWord      (iStartWord),
        .iRiceParam      (iRiceParam),
        .iResidual       (iResidual),
        .iValid          (iValid),
        .oReady          (oReady),
        .oWriteData      (oWriteData),
        .oWriteAddr      (oWriteAddr),
        .oWriteEnable    (oWriteEnable),
        .oDone           (oDone),
        .oEndAddr        (oEndAddr),
        .oEndBit         (oEndBit)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic signed [15:0] g_res[$];
    int                 g_k0, g_k1, g_ksw;
    int                 g_acc;
    logic [15:0]        wr_addr[$];
    logic [15:0]        wr_data[$];
    int                 acc_cyc[$];
    logic [15:0]        end_addr;
    logic [3:0]         end_bit;
    int                 done_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic int ac(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
    endfunction

    // Leaves reset asserted at a falling edge after two reset clock edges.
    task automatic do_reset(input logic [15:0] blk, input logic [3:0] pred,
                            input logic [3:0] porder, input logic [15:0] saddr,
                            input logic [3:0] sbit, input logic [15:0] sword);
        @(negedge clk);
        iReset          = 1'b1;
        iEnable         = 1'b1;
        iValid          = 1'b0;
        iResidual       = '0;
        iRiceParam      = '0;
        iBlockSize      = blk;
        iPredictorOrder = pred;
        iPartitionOrder = porder;
        iStartAddr      = saddr;
        iStartBit       = sbit;
        iStartWord      = sword;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Releases reset and streams g_res; en_mode 1 toggles iEnable every 3 cycles.
    task automatic run_block(input int en_mode, input int max_cyc);
        int cyc;
        int acc;
        int after_done;
        logic en;
        wr_addr.delete();
        wr_data.delete();
        acc_cyc.delete();
        done_cnt   = 0;
        acc        = 0;
        cyc        = 0;
        after_done = -1;
        end_addr   = 16'hFFFF;
        end_bit    = 4'h0;
        iReset     = 1'b0;
        while ((cyc < max_cyc) && ((after_done < 0) || (cyc - after_done < 8))) begin
            en         = (en_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
            iEnable    = en;
            iValid     = (acc < g_res.size());
            iResidual  = (acc < g_res.size()) ? g_res[acc] : 16'sd0;
            iRiceParam = 4'((acc >= g_ksw) ? g_k1 : g_k0);
            #1;
            if (oWriteEnable) begin
                wr_addr.push_back(oWriteAddr);
                wr_data.push_back(oWriteData);
            end
            if (iValid && oReady && iEnable) begin
                acc_cyc.push_back(cyc);
                acc++;
            end
            if (oDone) begin
                done_cnt++;
                end_addr = oEndAddr;
                end_bit  = oEndBit;
                if (after_done < 0) after_done = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        g_acc = acc;
        chk("done_seen", 32'(after_done >= 0), 32'd1);
    endtask

    // Block 4, k=2, residuals 0,-1,3,-4 from 0x10/15:
    // 0010 | 1 00 | 1 01 | 01 10 | 01 11 -> 0x2959, then "11" -> 0xC000.
    task automatic check_t1(input string tag);
        chk({tag, "_nwr"}, 32'(wr_data.size()), 32'd2);
        chk({tag, "_w0d"}, wd(0), 32'h2959);
        chk({tag, "_w0a"}, wa(0), 32'h0010);
        chk({tag, "_w1d"}, wd(1), 32'hC000);
        chk({tag, "_w1a"}, wa(1), 32'h0011);
        chk({tag, "_eaddr"}, 32'(end_addr), 32'h0011);
        chk({tag, "_ebit"}, 32'(end_bit), 32'd13);
        chk({tag, "_acc"}, 32'(g_acc), 32'd4);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int nbad6;
        int nwr5;

        // ---- 1: basic block, plus reset state ----
        do_reset(16'd4, 4'd0, 4'd0, 16'h0010, 4'd15, 16'h0000);
        #1;
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_we", 32'(oWriteEnable), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_wdata", 32'(oWriteData), 32'd0);
        chk("rst_eaddr", 32'(oEndAddr), 32'd0);
        chk("rst_ebit", 32'(oEndBit), 32'd15);
        g_res = '{16'sd0, -16'sd1, 16'sd3, -16'sd4};
        g_k0 = 2; g_k1 = 2; g_ksw = 0;
        run_block(0, 200);
        check_t1("t1");

        // ---- 2: same with enable toggling ----
        do_reset(16'd4, 4'd0, 4'd0, 16'h0010, 4'd15, 16'h0000);
        run_block(1, 400);
        check_t1("t2");

        // ---- 3: partial start word, k=0, residual 0: 0000 1 at bits 7..3 ----
        do_reset(16'd1, 4'd0, 4'd0, 16'h0020, 4'd7, 16'hABCD);
        g_res = '{16'sd0};
        g_k0 = 0; g_k1 = 0; g_ksw = 0;
        run_block(0, 100);
        chk("t3_nwr", 32'(wr_data.size()), 32'd1);
        chk("t3_w0d", wd(0), 32'hAB08);
        chk("t3_w0a", wa(0), 32'h0020);
        chk("t3_eaddr", 32'(end_addr), 32'h0020);
        chk("t3_ebit", 32'(end_bit), 32'd2);

        // ---- 4: block 8, pred 2, two partitions (k=1 then k=3) ----
        // 0001 10 10 0011 1000 | 1000 1000 1000 -> 0x1A38, 0x8880, end bit 3
        do_reset(16'd8, 4'd2, 4'd1, 16'h0030, 4'd15, 16'h0000);
        g_res = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        g_k0 = 1; g_k1 = 3; g_ksw = 2;
        run_block(0, 200);
        chk("t4_acc", 32'(g_acc), 32'd6);
        chk("t4_first_acc", 32'(ac(0)), 32'd4);
        chk("t4_gap01", 32'(ac(1) - ac(0)), 32'd3);
        chk("t4_gap12", 32'(ac(2) - ac(1)), 32'd7);
        chk("t4_gap23", 32'(ac(3) - ac(2)), 32'd5);
        chk("t4_nwr", 32'(wr_data.size()), 32'd2);
        chk("t4_w0d", wd(0), 32'h1A38);
        chk("t4_w0a", wa(0), 32'h0030);
        chk("t4_w1d", wd(1), 32'h8880);
        chk("t4_w1a", wa(1), 32'h0031);
        chk("t4_eaddr", 32'(end_addr), 32'h0031);
        chk("t4_ebit", 32'(end_bit), 32'd3);

        // ---- 5: reset while a full-word strobe is due in UNARY ----
        do_reset(16'd1, 4'd0, 4'd0, 16'h0010, 4'd15, 16'hFFFF);
        nwr5 = 0;
        iReset     = 1'b0;
        for (int c = 0; c < 17; c++) begin
            iEnable    = 1'b1;
            iValid     = 1'b1;
            iResidual  = -16'sd32768;
            iRiceParam = 4'd0;
            #1;
            if (oWriteEnable) nwr5++;
            @(negedge clk);
        end
        chk("t5_prewr", 32'(nwr5), 32'd0);
        iReset = 1'b1;
        #1;
        chk("t5_rst_we", 32'(oWriteEnable), 32'd0);
        do_reset(16'd4, 4'd0, 4'd0, 16'h0010, 4'd15, 16'h0000);
        g_res = '{16'sd0, -16'sd1, 16'sd3, -16'sd4};
        g_k0 = 2; g_k1 = 2; g_ksw = 0;
        run_block(0, 200);
        check_t1("t5");

        // ---- 7: empty partition, clamped k (15 -> 14): header 1110 only ----
        do_reset(16'd2, 4'd2, 4'd0, 16'h0040, 4'd15, 16'h0000);
        g_res.delete();
        g_k0 = 15; g_k1 = 15; g_ksw = 0;
        run_block(0, 100);
        chk("t7_acc", 32'(g_acc), 32'd0);
        chk("t7_nwr", 32'(wr_data.size()), 32'd1);
        chk("t7_w0d", wd(0), 32'hE000);
        chk("t7_w0a", wa(0), 32'h0040);
        chk("t7_ebit", 32'(end_bit), 32'd11);

        // ---- 6: k=0, residual -32768 -> u=65535: 4 header + 65535 zeros ----
        // 65539 zeros: 4096 zero words, then 000 1 -> 0x1000, end bit 11
        do_reset(16'd1, 4'd0, 4'd0, 16'h0100, 4'd15, 16'h0000);
        g_res = '{-16'sd32768};
        g_k0 = 0; g_k1 = 0; g_ksw = 0;
        run_block(0, 70000);
        chk("t6_nwr", 32'(wr_data.size()), 32'd4097);
        nbad6 = 0;
        for (int i = 0; i < 4096; i++) begin
            if ((wd(i) != 32'd0) || (wa(i) != 32'(16'h0100 + i))) nbad6++;
        end
        chk("t6_zero_words", 32'(nbad6), 32'd0);
        chk("t6_lastd", wd(4096), 32'h1000);
        chk("t6_lasta", wa(4096), 32'h1100);
        chk("t6_eaddr", 32'(end_addr), 32'h1100);
        chk("t6_ebit", 32'(end_bit), 32'd11);
        chk("t6_done", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
